draw_image_fader: RTL and testbench

- Parametrised full-screen image renderer for the VGA path.
- Maps the current pixel (x_pos, y_pos) to a word in a multi-image ROM, with integer down-scaling by 2^SCALE_SHIFT.
- Selects one of NUM_IMAGES stacked images and applies a frame-timed fade-out/swap/fade-in transition when a new image is requested.
- Sits between the VGA timing generator and the colour mux; the ROM is external, so the block drives its address and takes its data.

---
 rtl/draw_pkg.sv | 15 +
 rtl/pixel_dimmer.sv | 19 +
 rtl/draw_image_fader.sv | 145 ++++++++++++++
 tb/tb_draw_image_fader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types for the image fader: RGB888 pixel and transition FSM states.
package draw_pkg;

    localparam int unsigned PIX_W = 24;

    typedef logic [PIX_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        StIdle,
        StFadeOut,
        StSwap,
        StFadeIn
    } fade_state_e;

endpackage

// File: rtl/pixel_dimmer.sv
// Combinational per-channel brightness scaling: out = (in * level) >> FADE_BITS.
module pixel_dimmer
    import draw_pkg::*;
#(
    parameter int unsigned FADE_BITS = 4
) (
    input  rgb_t                 pixel_i,
    input  logic [FADE_BITS:0]   level_i,
    output rgb_t                 pixel_o
);

    localparam int unsigned PROD_W = 8 + FADE_BITS + 1;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        assign pixel_o[8*c +: 8] =
            8'((PROD_W'(pixel_i[8*c +: 8]) * PROD_W'(level_i)) >> FADE_BITS);
    end

endmodule

// File: rtl/draw_image_fader.sv
// Full-screen multi-image ROM renderer with frame-paced fade-out/swap/fade-in.
// Optional DRAW_IMAGE_BORDER_EN replaces out-of-image pixels with BORDER_COLOR.
module draw_image_fader
    import draw_pkg::*;
#(
    parameter int unsigned IMG_W       = 168,
    parameter int unsigned IMG_H       = 49,
    parameter int unsigned NUM_IMAGES  = 4,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned X_W         = 9,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned FADE_BITS   = 4,
    parameter int unsigned ROM_LAT     = 1,
`ifdef DRAW_IMAGE_BORDER_EN
    parameter rgb_t        BORDER_COLOR = 24'h000000,
`endif
    localparam int unsigned ADDR_W     = $clog2(NUM_IMAGES * IMG_W * IMG_H),
    localparam int unsigned SEL_W      = $clog2(NUM_IMAGES)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [X_W-1:0]    x_pos,
    input  logic [Y_W-1:0]    y_pos,
    input  logic              frame_start,
    input  logic [SEL_W-1:0]  img_sel,
    input  logic              img_load,
    output logic [ADDR_W-1:0] mem_addr,
    input  rgb_t              mem_q,
    output rgb_t              out_data,
    output logic [SEL_W-1:0]  cur_img,
    output logic              busy
);

    localparam int unsigned IMG_SZ = IMG_W * IMG_H;
    localparam logic [FADE_BITS:0] LEVEL_MAX = {1'b1, {FADE_BITS{1'b0}}};
    localparam logic [FADE_BITS:0] LEVEL_ONE = (FADE_BITS + 1)'(1);

    // A synchronous ROM always has at least one cycle of read latency.
    if (ROM_LAT < 1) begin : g_lat_check
        $error("ROM_LAT must be at least 1");
    end

    fade_state_e        state_q, state_d;
    logic [FADE_BITS:0] level_q, level_d;
    logic [SEL_W-1:0]   cur_img_q, cur_img_d;
    logic [SEL_W-1:0]   pend_q, pend_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    rgb_t               out_q, out_d;
    rgb_t               dimmed;

    assign addr_d = ADDR_W'(cur_img_q) * ADDR_W'(IMG_SZ)
                  + ADDR_W'(y_pos >> SCALE_SHIFT) * ADDR_W'(IMG_W)
                  + ADDR_W'(x_pos >> SCALE_SHIFT);

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        cur_img_d = cur_img_q;
        pend_d    = pend_q;
        unique case (state_q)
            StIdle: begin
                if (img_load && img_sel != cur_img_q && 32'(img_sel) < NUM_IMAGES) begin
                    state_d = StFadeOut;
                    pend_d  = img_sel;
                end
            end
            StFadeOut: begin
                // Hold one cycle at black before swapping.
                if (level_q == '0) begin
                    state_d = StSwap;
                end else if (frame_start) begin
                    level_d = level_q - LEVEL_ONE;
                end
            end
            StSwap: begin
                cur_img_d = pend_q;
                state_d   = StFadeIn;
            end
            StFadeIn: begin
                if (frame_start) begin
                    level_d = level_q + LEVEL_ONE;
                    if (level_q == LEVEL_MAX - LEVEL_ONE) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    pixel_dimmer #(
        .FADE_BITS(FADE_BITS)
    ) u_dimmer (
        .pixel_i(mem_q),
        .level_i(level_q),
        .pixel_o(dimmed)
    );

`ifdef DRAW_IMAGE_BORDER_EN
    // In-bounds flag travels with the address so it lines up with mem_q.
    logic          inb_now;
    logic [ROM_LAT:0] inb_q;

    assign inb_now = (32'(x_pos >> SCALE_SHIFT) < IMG_W) && (32'(y_pos >> SCALE_SHIFT) < IMG_H);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            inb_q <= '1;
        end else begin
            inb_q[0] <= inb_now;
            for (int i = 1; i <= int'(ROM_LAT); i++) begin
                inb_q[i] <= inb_q[i-1];
            end
        end
    end

    assign out_d = inb_q[ROM_LAT] ? dimmed : BORDER_COLOR;
`else
    assign out_d = dimmed;
`endif

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            level_q   <= LEVEL_MAX;
            cur_img_q <= '0;
            pend_q    <= '0;
            addr_q    <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cur_img_q <= cur_img_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            out_q     <= out_d;
        end
    end

    assign mem_addr = addr_q;
    assign out_data = out_q;
    assign cur_img  = cur_img_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_draw_image_fader.sv
// Directed bench for draw_image_fader with a one-cycle-latency ROM model.
module tb_draw_image_fader;

    localparam int X_W = 9;
    localparam int Y_W = 7;
    localparam int SEL_W = 2;
    localparam int ADDR_W = 16;

    logic              vga_clk = 1'b0;
    logic              reset;
    logic [X_W-1:0]    x_pos;
    logic [Y_W-1:0]    y_pos;
    logic              frame_start;
    logic [SEL_W-1:0]  img_sel;
    logic              img_load;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_q;
    logic [23:0]       out_data;
    logic [SEL_W-1:0]  cur_img;
    logic              busy;

    logic              rom_const_en;
    logic [23:0]       rom_const;

    int n_vec = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    // ROM content tags each word with its address so latency errors show up.
    always @(posedge vga_clk) begin
        mem_q <= rom_const_en ? rom_const : {8'hA5, mem_addr};
    end

    draw_image_fader #(
        .IMG_W(168)
`ifdef DRAW_IMAGE_BORDER_EN
        , .BORDER_COLOR(24'h0000FF)
`endif
    ) dut (
        .vga_clk(vga_clk),
        .reset(reset),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .frame_start(frame_start),
        .img_sel(img_sel),
        .img_load(img_load),
        .mem_addr(mem_addr),
        .mem_q(mem_q),
        .out_data(out_data),
        .cur_img(cur_img),
        .busy(busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(2);
    endtask

    task automatic load(input logic [SEL_W-1:0] sel);
        img_sel  = sel;
        img_load = 1'b1;
        tick(1);
        img_load = 1'b0;
    endtask

    // White pixel dimmed to level l: each channel (255*l)>>4.
    function automatic logic [23:0] white_at(input int l);
        logic [7:0] ch;
        ch = 8'((255 * l) >> 4);
        return {ch, ch, ch};
    endfunction

    initial begin
        reset = 1'b1;
        x_pos = '0;
        y_pos = '0;
        frame_start = 1'b0;
        img_sel = '0;
        img_load = 1'b0;
        rom_const_en = 1'b0;
        rom_const = '0;
        tick(2);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cur_img", 32'(cur_img), 32'd0);
        check_eq("rst_out", 32'(out_data), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);

        reset = 1'b0;
        x_pos = 9'd10;
        y_pos = 7'd4;
        tick(1);
        check_eq("addr_x10_y4", 32'(mem_addr), 32'd341);
        tick(2);
        check_eq("out_lat3", 32'(out_data), 32'hA50155);
        check_eq("idle_busy", 32'(busy), 32'd0);

        load(2'd0);
        tick(1);
        check_eq("same_idx_ignored", 32'(busy), 32'd0);

        // Accept with a coincident frame_start: that pulse must not step level.
        rom_const_en = 1'b1;
        rom_const = 24'hFFFFFF;
        img_sel = 2'd2;
        img_load = 1'b1;
        frame_start = 1'b1;
        tick(1);
        img_load = 1'b0;
        frame_start = 1'b0;
        check_eq("accept_busy", 32'(busy), 32'd1);
        tick(2);
        check_eq("accept_lvl16", 32'(out_data), 32'hFFFFFF);

        for (int l = 15; l >= 0; l--) begin
            pulse_frame();
            check_eq($sformatf("fade_out_l%0d", l), 32'(out_data), 32'(white_at(l)));
            if (l == 8) begin
                rom_const = 24'hFF8040;
                tick(2);
                check_eq("dim_ff8040_l8", 32'(out_data), 32'h7F4020);
                rom_const = 24'hFFFFFF;
                tick(2);
            end
        end
        tick(2);
        check_eq("swap_cur_img", 32'(cur_img), 32'd2);
        x_pos = '0;
        y_pos = '0;
        tick(1);
        check_eq("addr_img2_origin", 32'(mem_addr), 32'd16464);
        check_eq("fade_in_busy", 32'(busy), 32'd1);

        load(2'd3);
        for (int l = 1; l <= 16; l++) begin
            pulse_frame();
            check_eq($sformatf("fade_in_l%0d", l), 32'(out_data), 32'(white_at(l)));
            if (l == 15) check_eq("busy_l15", 32'(busy), 32'd1);
        end
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("busy_load_ignored", 32'(cur_img), 32'd2);
        tick(3);
        check_eq("no_stale_pending", 32'(busy), 32'd0);

        load(2'd2);
        tick(1);
        check_eq("same_idx2_ignored", 32'(busy), 32'd0);

        // Abort a fade at level 5 with reset.
        load(2'd1);
        for (int i = 0; i < 11; i++) pulse_frame();
        check_eq("pre_reset_l5", 32'(out_data), 32'h4F4F4F);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cur_img", 32'(cur_img), 32'd0);
        check_eq("abort_out", 32'(out_data), 32'd0);
        check_eq("abort_addr", 32'(mem_addr), 32'd0);
        tick(2);
        check_eq("abort_lvl16", 32'(out_data), 32'hFFFFFF);

`ifdef DRAW_IMAGE_BORDER_EN
        rom_const_en = 1'b0;
        x_pos = 9'd340;
        y_pos = '0;
        tick(3);
        check_eq("border_idle", 32'(out_data), 32'h0000FF);
        x_pos = 9'd10;
        y_pos = 7'd4;
        tick(3);
        check_eq("inside_idle", 32'(out_data), 32'hA50155);
        load(2'd3);
        for (int i = 0; i < 4; i++) pulse_frame();
        x_pos = 9'd340;
        tick(3);
        check_eq("border_fade", 32'(out_data), 32'h0000FF);
        x_pos = 9'd10;
        tick(3);
        check_eq("inside_fade_l12", 32'(out_data), 32'h7B003F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
